fetch_top: RTL and testbench
============================

# fetch_top

Instruction-fetch stage of the etcpu 5-stage RV32I pipeline: owns the program counter, drives the instruction-memory address, and presents the fetched instruction, PC and branch-prediction result to the decode stage through the IF/ID pipeline register. It is the producing end of the decode stage's `if_*` interface. It consumes the interlock stall and branch-flush/redirect from downstream and trains a direct-mapped BTB with 2-bit counters from execute-stage branch resolution.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset
- `BTB_DEPTH`, 16, BTB entries; power of 2, ≥2; index = pc[log2(BTB_DEPTH)+1:2], tag = remaining upper PC bits (pc[31:log2(BTB_DEPTH)+2])

- `clk` in 1: clock, all state on rising edge
- `rst` in 1: synchronous reset, active high
- `imem_addr` out 32: instruction memory address (= current PC)
- `imem_rdata` in 32: instruction word, combinational same-cycle return for `imem_addr`
- `intrlock_bubble` in 1: decode interlock stall; hold PC and IF/ID
- `ex_branch_flush` in 1: misprediction/redirect from execute
- `ex_redirect_pc` in 32: correct next PC, valid with `ex_branch_flush`
- `ex_bp_upd_vld` in 1: resolved control-transfer update strobe
- `ex_bp_upd_pc` in 32: PC of resolved branch
- `ex_bp_upd_taken` in 1: actual outcome
- `ex_bp_upd_target` in 32: actual taken target
- `if_inst` out 32: IF/ID instruction
- `if_pc` out 32: IF/ID PC
- `if_branch_taken` out 1: instruction was predicted taken
- `if_branch_nt_pc` out 32: fall-through PC (`if_pc`+4)

## Operation
- Fetch: `imem_addr` = `pc`. Lookup BTB at index(`pc`); `pred_taken` = valid & tag match & counter[1]. `next_pc` = `pred_taken` ? BTB target : `pc`+4 (32-bit wrap, 32'hFFFF_FFFC+4 = 0).
- Per cycle, priority: `rst` > `ex_branch_flush` > `intrlock_bubble` > normal.
  - `rst`: `pc`←`RESET_PC`; IF/ID ← {BUBBLE (32'h0000_0013, addi x0,x0,0), `RESET_PC`, 0, `RESET_PC`+4}; all BTB valid bits cleared; counters/targets/tags don't-care.
  - flush: `pc`←`ex_redirect_pc`; IF/ID `if_inst`←BUBBLE, `if_branch_taken`←0, `if_pc`/`if_branch_nt_pc` ← current `pc`/`pc`+4. Stall ignored.
  - stall: `pc` and IF/ID hold.
  - normal: `pc`←`next_pc`; IF/ID ← {`imem_rdata`, `pc`, `pred_taken`, `pc`+4}.
- BTB update on `ex_bp_upd_vld` (independent of stall/flush, blocked only by `rst`), at index(`ex_bp_upd_pc`):
  - hit (valid & tag match): counter saturating +1 if taken, −1 if not (range 0..3); target←`ex_bp_upd_target` when taken.
  - miss & taken: allocate/overwrite: valid←1, tag, target, counter←2'b10.
  - miss & not taken: no change.
- Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.

## Timing
- PC→`if_*` latency 1 cycle; flush-to-first-correct-instruction in IF/ID: 1 cycle, with exactly one BUBBLE presented in the flush cycle's IF/ID update.
- BTB read combinational; write visible the cycle after update. Same-cycle lookup and update of one index returns pre-update contents.
- Stall of N cycles holds `if_*` for N cycles and `imem_addr` constant.
- Reset asserted mid-operation discards in-flight fetch and any same-cycle update; first fetch from `RESET_PC` the cycle after `rst` deasserts.

## Configuration
- `FETCH_BPRED_EN` defined: BTB and counters implemented as above.
- Undefined: no BTB storage; `pred_taken` tied 0, `next_pc` always `pc`+4, `if_branch_taken` always 0; `ex_bp_upd_*` ignored. Flush/stall/reset behaviour unchanged.

## Test plan
- Reset: hold `rst` 2 cycles, `RESET_PC`=0 → `if_inst`=32'h13, `if_pc`=0, `if_branch_taken`=0; first cycle after release `imem_addr`=0, next `if_pc`=0, `imem_addr`=4.
- Sequential + stall: fetch 0,4,8; assert `intrlock_bubble` 3 cycles at `pc`=8 → `imem_addr` stays 8, `if_pc` stays 4; release → `if_pc`=8 then 12.
- Flush over stall: `ex_branch_flush`=1, `ex_redirect_pc`=0x200, `intrlock_bubble`=1 same cycle → next cycle `if_inst`=BUBBLE, `imem_addr`=0x200; following cycle `if_pc`=0x200.
- Training (`FETCH_BPRED_EN`): update pc 0x40 taken target 0x100 once → next fetch at 0x40 gives `if_branch_taken`=1, `imem_addr` 0x100 next, `if_branch_nt_pc`=0x44; then two not-taken updates → counter 00, fetch 0x40 predicts not taken (next 0x44).
- Saturation/alias: four taken updates at 0x40 then one not-taken → still predicts taken; taken update at 0x80 (BTB_DEPTH=16, same index) replaces entry → 0x40 no longer hits.
- Macro off: same training sequence → `if_branch_taken` always 0, PC strictly +4 except on flush.

Source files
------------

// File: rtl/fetch_top.sv
// fetch_top: RV32I instruction fetch stage -- PC, imem address, IF/ID register, optional BTB predictor.
// Latency: PC to if_* is 1 cycle; BTB read is combinational, a BTB write is visible the following cycle.
// Backpressure: intrlock_bubble holds PC and IF/ID; ex_branch_flush overrides the stall. BTB built only with FETCH_BPRED_EN.
module fetch_top #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BTB_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        intrlock_bubble,
  input  logic        ex_branch_flush,
  input  logic [31:0] ex_redirect_pc,
  input  logic        ex_bp_upd_vld,
  input  logic [31:0] ex_bp_upd_pc,
  input  logic        ex_bp_upd_taken,
  input  logic [31:0] ex_bp_upd_target,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  output logic        if_branch_taken,
  output logic [31:0] if_branch_nt_pc
);

  localparam int          IDX_W  = $clog2(BTB_DEPTH);
  localparam int          TAG_W  = 30 - IDX_W;
  localparam logic [31:0] BUBBLE = 32'h0000_0013;

  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] ifpc_q, ifpc_d;
  logic        taken_q, taken_d;
  logic [31:0] ntpc_q, ntpc_d;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic        pred_taken;

  assign pc_plus4  = pc_q + 32'd4;
  assign imem_addr = pc_q;

`ifdef FETCH_BPRED_EN
  logic [BTB_DEPTH-1:0] vld_q;
  logic [TAG_W-1:0]     tag_q [BTB_DEPTH];
  logic [31:0]          tgt_q [BTB_DEPTH];
  logic [1:0]           cnt_q [BTB_DEPTH];
  logic [IDX_W-1:0]     rd_idx, up_idx;
  logic [TAG_W-1:0]     rd_tag, up_tag;
  logic                 up_hit;
  logic                 unused_upd_lsb;

  assign rd_idx         = pc_q[IDX_W+1:2];
  assign rd_tag         = pc_q[31:IDX_W+2];
  assign up_idx         = ex_bp_upd_pc[IDX_W+1:2];
  assign up_tag         = ex_bp_upd_pc[31:IDX_W+2];
  assign up_hit         = vld_q[up_idx] && (tag_q[up_idx] == up_tag);
  assign unused_upd_lsb = ^ex_bp_upd_pc[1:0];

  // Lookup reads pre-update contents, so a same-cycle update to this index is not seen yet.
  assign pred_taken = vld_q[rd_idx] && (tag_q[rd_idx] == rd_tag) && cnt_q[rd_idx][1];
  assign next_pc    = pred_taken ? tgt_q[rd_idx] : pc_plus4;

  // Valid bits: the only BTB state that reset touches; a taken miss allocates the entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else if (ex_bp_upd_vld && !up_hit && ex_bp_upd_taken) begin
      vld_q[up_idx] <= 1'b1;
    end
  end

  // Tag/target/counter storage: saturating training on hit, allocate weak-taken on taken miss.
  always_ff @(posedge clk) begin
    if (!rst && ex_bp_upd_vld) begin
      if (up_hit) begin
        if (ex_bp_upd_taken) begin
          tgt_q[up_idx] <= ex_bp_upd_target;
          if (cnt_q[up_idx] != 2'b11) cnt_q[up_idx] <= cnt_q[up_idx] + 2'b01;
        end else if (cnt_q[up_idx] != 2'b00) begin
          cnt_q[up_idx] <= cnt_q[up_idx] - 2'b01;
        end
      end else if (ex_bp_upd_taken) begin
        tag_q[up_idx] <= up_tag;
        tgt_q[up_idx] <= ex_bp_upd_target;
        cnt_q[up_idx] <= 2'b10;
      end
    end
  end
`else
  logic unused_upd;

  assign unused_upd = ^{ex_bp_upd_vld, ex_bp_upd_pc, ex_bp_upd_taken, ex_bp_upd_target};
  assign pred_taken = 1'b0;
  assign next_pc    = pc_plus4;
`endif

  // Next-state for PC and IF/ID: flush beats stall, stall holds everything.
  always_comb begin
    pc_d    = pc_q;
    inst_d  = inst_q;
    ifpc_d  = ifpc_q;
    taken_d = taken_q;
    ntpc_d  = ntpc_q;
    if (ex_branch_flush) begin
      pc_d    = ex_redirect_pc;
      inst_d  = BUBBLE;
      ifpc_d  = pc_q;
      taken_d = 1'b0;
      ntpc_d  = pc_plus4;
    end else if (!intrlock_bubble) begin
      pc_d    = next_pc;
      inst_d  = imem_rdata;
      ifpc_d  = pc_q;
      taken_d = pred_taken;
      ntpc_d  = pc_plus4;
    end
  end

  // PC and IF/ID registers with synchronous reset to a bubble at RESET_PC.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      inst_q  <= BUBBLE;
      ifpc_q  <= RESET_PC;
      taken_q <= 1'b0;
      ntpc_q  <= RESET_PC + 32'd4;
    end else begin
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      ifpc_q  <= ifpc_d;
      taken_q <= taken_d;
      ntpc_q  <= ntpc_d;
    end
  end

  assign if_inst         = inst_q;
  assign if_pc           = ifpc_q;
  assign if_branch_taken = taken_q;
  assign if_branch_nt_pc = ntpc_q;

endmodule

// File: tb/tb_fetch_top.sv
// tb_fetch_top: directed table, hand-written predictor sequences and random traffic against a queue/array reference.
// Latency: outputs sampled 1ns after each rising edge.
// Backpressure: stall, flush and reset are driven directly as stimulus.
module tb_fetch_top;

  localparam int          DEPTH  = 16;
  localparam int          IDXW   = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] BUB    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, bubble, flush, upd_vld, upd_taken;
  logic [31:0] redir, upd_pc, upd_tgt;
  logic [31:0] imem_addr, imem_rdata, if_inst, if_pc, if_nt_pc;
  logic        if_taken;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fetch_top #(.RESET_PC(RST_PC), .BTB_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .intrlock_bubble(bubble), .ex_branch_flush(flush), .ex_redirect_pc(redir),
    .ex_bp_upd_vld(upd_vld), .ex_bp_upd_pc(upd_pc), .ex_bp_upd_taken(upd_taken),
    .ex_bp_upd_target(upd_tgt), .if_inst(if_inst), .if_pc(if_pc),
    .if_branch_taken(if_taken), .if_branch_nt_pc(if_nt_pc)
  );

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  // Instruction memory with same-cycle combinational return.
  always_comb imem_rdata = mem(imem_addr);

  // Reference model: architectural PC, IF/ID contents, and a BTB held as plain arrays.
  logic [31:0] m_pc, m_inst, m_ifpc, m_nt;
  logic        m_taken;
  bit          m_v   [DEPTH];
  int unsigned m_tag [DEPTH];
  logic [31:0] m_tgt [DEPTH];
  int          m_cnt [DEPTH];

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] a);
    return int'(a >> (2 + IDXW));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit          pred = 1'b0;
    logic [31:0] npc;
    int          i = idx_of(m_pc);
    int          u = idx_of(upd_pc);
`ifdef FETCH_BPRED_EN
    pred = m_v[i] && (m_tag[i] == tag_of(m_pc)) && (m_cnt[i] >= 2);
`endif
    npc = pred ? m_tgt[i] : m_pc + 32'd4;
    if (rst) begin
      m_pc = RST_PC; m_inst = BUB; m_ifpc = RST_PC; m_taken = 1'b0; m_nt = RST_PC + 32'd4;
      for (int k = 0; k < DEPTH; k++) m_v[k] = 1'b0;
    end else begin
`ifdef FETCH_BPRED_EN
      if (upd_vld) begin
        if (m_v[u] && m_tag[u] == tag_of(upd_pc)) begin
          if (upd_taken) begin
            m_cnt[u] = (m_cnt[u] < 3) ? m_cnt[u] + 1 : 3;
            m_tgt[u] = upd_tgt;
          end else begin
            m_cnt[u] = (m_cnt[u] > 0) ? m_cnt[u] - 1 : 0;
          end
        end else if (upd_taken) begin
          m_v[u] = 1'b1; m_tag[u] = tag_of(upd_pc); m_tgt[u] = upd_tgt; m_cnt[u] = 2;
        end
      end
`endif
      if (flush) begin
        m_inst = BUB; m_ifpc = m_pc; m_taken = 1'b0; m_nt = m_pc + 32'd4; m_pc = redir;
      end else if (!bubble) begin
        m_inst = mem(m_pc); m_ifpc = m_pc; m_taken = pred; m_nt = m_pc + 32'd4; m_pc = npc;
      end
    end
  endtask

  // Drive one cycle of inputs, clock it, then compare every output against the reference.
  task automatic step(input logic r, input logic f, input logic [31:0] rp, input logic b,
                      input logic uv, input logic [31:0] up, input logic ut, input logic [31:0] utg);
    rst = r; flush = f; redir = rp; bubble = b;
    upd_vld = uv; upd_pc = up; upd_taken = ut; upd_tgt = utg;
    model_step();
    @(posedge clk);
    #1;
    chk("model_imem_addr", imem_addr, m_pc);
    chk("model_if_inst", if_inst, m_inst);
    chk("model_if_pc", if_pc, m_ifpc);
    chk("model_if_taken", {31'b0, if_taken}, {31'b0, m_taken});
    chk("model_if_nt_pc", if_nt_pc, m_nt);
  endtask

  task automatic go(input logic f, input logic [31:0] rp, input logic b,
                    input logic uv, input logic [31:0] up, input logic ut, input logic [31:0] utg);
    step(1'b0, f, rp, b, uv, up, ut, utg);
  endtask

  typedef struct {
    logic        r, f, b;
    logic [31:0] rp;
    logic [31:0] e_addr, e_pc;
    logic        e_bub;
  } vec_t;

  vec_t vecs [13];
  bit   exp_tk;
  logic [31:0] exp_nx;

  initial begin
    // Reset, sequential fetch, 3-cycle stall at pc=8, flush over stall, 32-bit wrap.
    vecs[0]  = '{1, 0, 0, 32'h0,         32'h0,         32'h0,         1};
    vecs[1]  = '{1, 0, 0, 32'h0,         32'h0,         32'h0,         1};
    vecs[2]  = '{0, 0, 0, 32'h0,         32'h4,         32'h0,         0};
    vecs[3]  = '{0, 0, 0, 32'h0,         32'h8,         32'h4,         0};
    vecs[4]  = '{0, 0, 1, 32'h0,         32'h8,         32'h4,         0};
    vecs[5]  = '{0, 0, 1, 32'h0,         32'h8,         32'h4,         0};
    vecs[6]  = '{0, 0, 1, 32'h0,         32'h8,         32'h4,         0};
    vecs[7]  = '{0, 0, 0, 32'h0,         32'hC,         32'h8,         0};
    vecs[8]  = '{0, 0, 0, 32'h0,         32'h10,        32'hC,         0};
    vecs[9]  = '{0, 1, 1, 32'h200,       32'h200,       32'h10,        1};
    vecs[10] = '{0, 0, 0, 32'h0,         32'h204,       32'h200,       0};
    vecs[11] = '{0, 1, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h204,       1};
    vecs[12] = '{0, 0, 0, 32'h0,         32'h0,         32'hFFFF_FFFC, 0};

    rst = 1'b1; flush = 1'b0; bubble = 1'b0; redir = '0;
    upd_vld = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_tgt = '0;
    m_pc = '0; m_inst = '0; m_ifpc = '0; m_taken = 1'b0; m_nt = '0;
    for (int k = 0; k < DEPTH; k++) begin
      m_v[k] = 1'b0; m_tag[k] = 0; m_tgt[k] = '0; m_cnt[k] = 0;
    end

    for (int n = 0; n < 13; n++) begin
      step(vecs[n].r, vecs[n].f, vecs[n].rp, vecs[n].b, 1'b0, 32'h0, 1'b0, 32'h0);
      chk($sformatf("vec%0d_imem_addr", n), imem_addr, vecs[n].e_addr);
      chk($sformatf("vec%0d_if_pc", n), if_pc, vecs[n].e_pc);
      chk($sformatf("vec%0d_if_inst", n), if_inst, vecs[n].e_bub ? BUB : mem(vecs[n].e_pc));
      chk($sformatf("vec%0d_if_nt_pc", n), if_nt_pc, vecs[n].e_pc + 32'd4);
      chk($sformatf("vec%0d_if_taken", n), {31'b0, if_taken}, 32'h0);
    end

    // Training: one taken update at 0x40 while redirecting there.
`ifdef FETCH_BPRED_EN
    exp_tk = 1'b1; exp_nx = 32'h100;
`else
    exp_tk = 1'b0; exp_nx = 32'h44;
`endif
    go(1'b1, 32'h40, 1'b0, 1'b1, 32'h40, 1'b1, 32'h100);
    go(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("train_if_taken", {31'b0, if_taken}, {31'b0, exp_tk});
    chk("train_next_addr", imem_addr, exp_nx);
    chk("train_if_nt_pc", if_nt_pc, 32'h44);
    chk("train_if_pc", if_pc, 32'h40);

    // Two not-taken updates drive the counter to strong not-taken.
    go(1'b0, 32'h0, 1'b1, 1'b1, 32'h40, 1'b0, 32'h0);
    go(1'b1, 32'h40, 1'b0, 1'b1, 32'h40, 1'b0, 32'h0);
    go(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("untrain_if_taken", {31'b0, if_taken}, 32'h0);
    chk("untrain_next_addr", imem_addr, 32'h44);

    // Four taken then one not-taken: counter saturates and still predicts taken.
    for (int k = 0; k < 3; k++) go(1'b0, 32'h0, 1'b1, 1'b1, 32'h40, 1'b1, 32'h100);
    go(1'b1, 32'h40, 1'b0, 1'b1, 32'h40, 1'b1, 32'h100);
    go(1'b0, 32'h0, 1'b1, 1'b1, 32'h40, 1'b0, 32'h0);
    go(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("sat_if_taken", {31'b0, if_taken}, {31'b0, exp_tk});
    chk("sat_next_addr", imem_addr, exp_nx);

    // Aliasing 0x80 replaces the 0x40 entry.
    go(1'b0, 32'h0, 1'b1, 1'b1, 32'h80, 1'b1, 32'h300);
    go(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    go(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("alias_old_taken", {31'b0, if_taken}, 32'h0);
    chk("alias_old_next", imem_addr, 32'h44);
    go(1'b1, 32'h80, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    go(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("alias_new_taken", {31'b0, if_taken}, {31'b0, exp_tk});
    chk("alias_new_next", imem_addr, exp_tk ? 32'h300 : 32'h84);

    // Reset with a same-cycle update discards the update.
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1, 32'h500);
    go(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("rst_upd_next", imem_addr, 32'h4);
    chk("rst_upd_taken", {31'b0, if_taken}, 32'h0);

    // Random traffic confined to a small PC window so BTB hits and aliases are frequent.
    for (int n = 0; n < 1500; n++) begin
      step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 10, 32'(4 * $urandom_range(0, 255)),
           $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 40, 32'(4 * $urandom_range(0, 255)),
           1'($urandom_range(0, 1)), 32'(4 * $urandom_range(0, 255)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
